// File: rtl/five_way_sum_splitter_pkg.sv
// Shared constants and types for the five-way sum splitter.
//
// The splitter turns a SUM_W-bit total into N_PARTS operands of PART_W bits
// each. Each operand is the greedy choice min(remaining, PART_MAX). The widths
// must satisfy 2^SUM_W-1 >= N_PARTS*PART_MAX. The defaults give 127 >= 75, so
// the running remainder can never wrap.
package five_way_sum_splitter_pkg;

    localparam int N_PARTS  = 5;
    localparam int PART_W   = 4;
    localparam int SUM_W    = 7;
    localparam int IDX_W    = 3;

    localparam int PART_MAX = (1 << PART_W) - 1;
    localparam int SUM_MAX  = N_PARTS * PART_MAX;

    // The widths above must leave room for SUM_MAX in SUM_W bits and for
    // N_PARTS-1 in IDX_W bits.
    localparam bit PARAMS_OK = (((1 << SUM_W) - 1) >= SUM_MAX) &&
                               (((1 << IDX_W) - 1) >= (N_PARTS - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        FIN  = 2'd2
    } state_t;

    // A total can be split only if N_PARTS full-scale operands can cover it.
    function automatic logic total_in_range(input logic [SUM_W-1:0] total);
        return total <= SUM_W'(SUM_MAX);
    endfunction

endpackage

// File: rtl/five_way_sum_splitter_if.sv
// Request / operand-stream bundle for the five-way sum splitter.
//
// Signals:
//   start, total  - split request; total is captured when start is accepted
//   out_ready     - consumer accepts the operand on offer
//   part          - current operand
//   part_valid    - part and part_idx are valid
//   part_idx      - operand index, 0..N_PARTS-1
//   busy          - a split is in progress
//   done          - one-cycle pulse after the last operand is taken
//   err           - one-cycle pulse when a request total is out of range
//
// Modports:
//   slave  - the splitter
//   master - the requester / operand consumer
interface five_way_sum_splitter_if;
    import five_way_sum_splitter_pkg::*;

    logic              start;
    logic [SUM_W-1:0]  total;
    logic              out_ready;
    logic [PART_W-1:0] part;
    logic              part_valid;
    logic [IDX_W-1:0]  part_idx;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  start,
        input  total,
        input  out_ready,
        output part,
        output part_valid,
        output part_idx,
        output busy,
        output done,
        output err
    );

    modport master (
        output start,
        output total,
        output out_ready,
        input  part,
        input  part_valid,
        input  part_idx,
        input  busy,
        input  done,
        input  err
    );

endinterface

// File: rtl/five_way_sum_splitter_part_clamp.sv
// Greedy operand selection for the splitter.
//
// This block is purely combinational. From one SUM_W-bit remainder it gives:
//   part - min(remaining, PART_MAX)
//   rest - remaining - part
// The top uses the same result for the operand it presents and for the
// remainder it keeps after the handshake.
//
// Ports:
//   remaining  in   SUM_W   value still to be distributed
//   part       out  PART_W  operand to emit now
//   rest       out  SUM_W   remainder after this operand
module five_way_sum_splitter_part_clamp
    import five_way_sum_splitter_pkg::*;
(
    input  logic [SUM_W-1:0]  remaining,
    output logic [PART_W-1:0] part,
    output logic [SUM_W-1:0]  rest
);

    localparam logic [SUM_W-1:0] PART_MAX_EXT = SUM_W'(PART_MAX);

    logic [SUM_W-1:0] clamp;

    always_comb begin
        clamp = remaining;
        if (remaining > PART_MAX_EXT) begin
            clamp = PART_MAX_EXT;
        end
        // clamp <= PART_MAX here, so the narrowing drops only zero bits and
        // the subtraction below cannot underflow.
        part = PART_W'(clamp);
        rest = remaining - clamp;
    end

endmodule

// File: rtl/five_way_sum_splitter.sv
// Five-way sum splitter: the inverse of the five-operand 4-bit summing path.
//
// The block takes a SUM_W-bit total and emits N_PARTS operands, one per
// handshake. Each operand is min(remaining, PART_MAX), so the operands always
// add back to the captured total. Once the remainder reaches zero, the
// trailing operands are zero. A total above SUM_MAX is rejected with a
// one-cycle err pulse.
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   synchronous reset, active high, priority over everything
//   bus   slave modport of five_way_sum_splitter_if (request and operand stream)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; an out-of-range total raises err
// EMIT  | presenting operand part_idx; advances on out_ready
// FIN   | one-cycle done pulse, busy low, then back to IDLE
module five_way_sum_splitter
    import five_way_sum_splitter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    five_way_sum_splitter_if.slave bus
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PARTS - 1);

    state_t            state_q;
    state_t            state_d;
    logic [SUM_W-1:0]  remaining_q;
    logic [SUM_W-1:0]  remaining_d;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic              err_q;
    logic              err_d;

    logic [PART_W-1:0] clamp_part;
    logic [SUM_W-1:0]  clamp_rest;
    logic              emitting;
    logic              handshake;

    five_way_sum_splitter_part_clamp u_part_clamp (
        .remaining (remaining_q),
        .part      (clamp_part),
        .rest      (clamp_rest)
    );

    // State, remainder, index and err are all registered. The operand is
    // derived combinationally from the registered remainder only. As a result,
    // part, part_idx and part_valid do not depend on out_ready within the cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
        end
    end

    assign emitting  = (state_q == EMIT);
    assign handshake = emitting && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (total_in_range(bus.total)) begin
                        remaining_d = bus.total;
                        idx_d       = '0;
                        state_d     = EMIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            EMIT: begin
                if (handshake) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = FIN;
                    end else begin
                        remaining_d = clamp_rest;
                        idx_d       = idx_q + IDX_W'(1);
                    end
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outside EMIT, part is forced to zero so that IDLE and FIN show a quiet
    // bus and not a stale operand.
    assign bus.part       = emitting ? clamp_part : '0;
    assign bus.part_valid = emitting;
    assign bus.part_idx   = idx_q;
    assign bus.busy       = emitting;
    assign bus.done       = (state_q == FIN);
    assign bus.err        = err_q;

endmodule

// File: tb/tb_five_way_sum_splitter.sv
module tb_five_way_sum_splitter;
    import five_way_sum_splitter_pkg::*;

    logic clk;
    logic rst;
    int   cyc;

    five_way_sum_splitter_if bus();

    five_way_sum_splitter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    typedef struct {
        int idx;
        int part;
    } exp_t;

    exp_t exp_parts[$];
    int   exp_totals[$];
    int   exp_err;
    int   n_acc;
    logic [6:0] sum_acc;

    int vectors;
    int miscompares;

    bit rand_ready;

    task automatic chk(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model: greedy split by plain arithmetic on an integer.
    task automatic push_split(input int t);
        int rem;
        int p;
        rem = t;
        for (int i = 0; i < 5; i++) begin
            p = (rem > 15) ? 15 : rem;
            rem = rem - p;
            exp_parts.push_back('{idx: i, part: p});
        end
        exp_totals.push_back(t);
    endtask

    // ---------------- random ready generator ----------------
    always @(posedge clk) begin
        #1;
        if (rand_ready) bus.out_ready = (($urandom % 4) != 0);
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t e;
        int   t;
        bit   prev_stall;
        int   prev_part;
        int   prev_idx;
        prev_stall = 1'b0;
        prev_part  = 0;
        prev_idx   = 0;
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                chk("hold_valid", int'(bus.part_valid), 1);
                chk("hold_part", int'(bus.part), prev_part);
                chk("hold_idx", int'(bus.part_idx), prev_idx);
            end
            prev_stall = bus.part_valid && !bus.out_ready;
            prev_part  = int'(bus.part);
            prev_idx   = int'(bus.part_idx);

            if (bus.part_valid) begin
                chk("busy_while_valid", int'(bus.busy), 1);
                if (bus.out_ready) begin
                    if (exp_parts.size() == 0) begin
                        flag("unexpected_part");
                    end else begin
                        e = exp_parts.pop_front();
                        chk("part_value", int'(bus.part), e.part);
                        chk("part_idx", int'(bus.part_idx), e.idx);
                        sum_acc = sum_acc + 7'(bus.part);
                        n_acc++;
                    end
                end
            end

            if (bus.done) begin
                if (exp_totals.size() == 0) begin
                    flag("unexpected_done");
                end else begin
                    t = exp_totals.pop_front();
                    chk("parts_before_done", n_acc, 5);
                    chk("roundtrip_sum", int'(sum_acc), t);
                end
                n_acc   = 0;
                sum_acc = '0;
            end

            if (bus.err) begin
                if (exp_err == 0) flag("unexpected_err");
                else exp_err--;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                return;
            end
        end
        flag("done_timeout");
    endtask

    task automatic split(input int t, input bit chk_lat);
        int t0;
        bit ok;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.total = 7'(t);
        if (t <= 75) push_split(t);
        else exp_err++;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.total = 7'($urandom);
        t0 = cyc;
        if (t <= 75) begin
            wait_done(ok);
            if (ok) begin
                if (chk_lat) chk("done_latency", cyc - t0 + 1, 6);
                chk("busy_in_done_cycle", int'(bus.busy), 0);
            end
        end else begin
            @(negedge clk);
            chk("err_pulse", int'(bus.err), 1);
            chk("err_busy", int'(bus.busy), 0);
            chk("err_no_valid", int'(bus.part_valid), 0);
            @(negedge clk);
            chk("err_one_cycle", int'(bus.err), 0);
            chk("err_no_valid2", int'(bus.part_valid), 0);
            chk("err_busy2", int'(bus.busy), 0);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, int'(bus.part_valid), 0);
        chk({tag, "_part"}, int'(bus.part), 0);
        chk({tag, "_idx"}, int'(bus.part_idx), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_err"}, int'(bus.err), 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : driver
        bit ok;
        bit seen;
        vectors     = 0;
        miscompares = 0;
        exp_err     = 0;
        n_acc       = 0;
        sum_acc     = '0;
        rand_ready  = 1'b0;
        bus.start     = 1'b0;
        bus.total     = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("idle");

        // Full scale, zero and partial totals with out_ready held high.
        split(75, 1'b1);
        @(negedge clk);
        chk("busy_after_done", int'(bus.busy), 0);
        split(37, 1'b1);
        split(0, 1'b1);

        // Out of range, then a normal request.
        split(80, 1'b0);
        split(20, 1'b1);

        // A start raised in the done cycle is ignored.
        bus.start = 1'b1;
        bus.total = 7'd10;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("start_in_fin_ignored", int'(bus.part_valid), 0);

        // Back-pressure at idx 1; a second start during the stall is ignored.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.start = 1'b1;
        bus.total = 7'd50;
        push_split(50);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("stall_first_idx", int'(bus.part_idx), 0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.start = 1'b1;
        bus.total = 7'd9;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_valid", int'(bus.part_valid), 1);
            chk("stall_part", int'(bus.part), 15);
            chk("stall_idx", int'(bus.part_idx), 1);
            @(posedge clk); #1;
            if (k == 0) bus.start = 1'b0;
            if (k == 2) bus.out_ready = 1'b1;
        end
        wait_done(ok);

        // Reset in the middle of a split, while idx 2 is on offer.
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        bus.total = 7'd60;
        push_split(60);
        @(posedge clk); #1;
        bus.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.part_valid && bus.part_idx == 3'd2) seen = 1'b1;
        end
        if (!seen) flag("idx2_timeout");
        rst = 1'b1;
        @(posedge clk); #1;
        exp_parts.delete();
        exp_totals.delete();
        n_acc   = 0;
        sum_acc = '0;
        @(negedge clk);
        chk_quiet("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("after_reset_no_done", int'(bus.done), 0);
        chk("after_reset_no_valid", int'(bus.part_valid), 0);
        split(33, 1'b1);

        // Random totals (some out of range) with random back-pressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            split($urandom_range(0, 90), 1'b0);
        end
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(negedge clk);

        chk("leftover_parts", exp_parts.size(), 0);
        chk("leftover_totals", exp_totals.size(), 0);
        chk("leftover_err", exp_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/five_way_sum_splitter.md
Name: five_way_sum_splitter

Overview:
- Inverse of the five-operand 4-bit summing block: takes a 7-bit total and emits five 4-bit operands, one per handshake, whose sum equals the total.
- Greedy split: each operand is min(remaining, 15).
- Drives the operand-load side of the five-input adder path. Also serves as a stimulus generator for round-trip checks against that adder.

Parameters:
- N_PARTS, 5, number of operands emitted per request.
- PART_W, 4, operand width; max operand is 2^PART_W-1 = 15.
- SUM_W, 7, total width; must satisfy 2^SUM_W-1 >= N_PARTS*(2^PART_W-1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to split; sampled only in IDLE.
- total  input  SUM_W  value to split; captured on accepted start.
- out_ready  input  1  consumer accepts current operand.
- part  output  PART_W  current operand.
- part_valid  output  1  part/part_idx are valid.
- part_idx  output  3  index 0..N_PARTS-1 of current operand.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse after last operand accepted.
- err  output  1  one-cycle pulse when total exceeds N_PARTS*15.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE; part=0, part_valid=0, part_idx=0, busy=0, done=0, err=0; internal remaining=0.
- rst has priority over every other input. If rst is asserted mid-operation, the sequence is abandoned at the next edge with no done or err.
- States: IDLE, EMIT, FIN.
- IDLE, start=1, total <= N_PARTS*15 (75):
  - remaining<=total, part_idx<=0, go to EMIT.
  - busy=1 from the next cycle.
- IDLE, start=1, total > 75:
  - err=1 for exactly one cycle (the cycle after start).
  - Stay in IDLE; no part_valid.
- EMIT:
  - part_valid=1 and part=min(remaining,15), both combinational from registered state.
  - Handshake fires on part_valid & out_ready.
  - On handshake with part_idx<N_PARTS-1: remaining<=remaining-part, part_idx<=part_idx+1.
  - On handshake with part_idx==N_PARTS-1: go to FIN.
  - Without out_ready, part, part_idx and part_valid hold stable (no combinational dependence on out_ready).
- FIN: done=1, busy=0 for one cycle, then IDLE. part_valid=0.
- Earliest accepted start is the cycle after done.
- Latency:
  - First part_valid is 1 cycle after the accepted start.
  - With out_ready held high: operands on cycles 1..5, done on cycle 6.
- Exactly N_PARTS operands are always emitted; trailing operands are 0 once remaining reaches 0.
- Invariants:
  - Sum of emitted parts == captured total.
  - No operand exceeds 15.
  - remaining never underflows.
- start while busy is ignored; total changes while busy are ignored.
- Arithmetic width:
  - remaining is SUM_W bits unsigned.
  - The min compare is against a zero-extended constant.
  - No wrap-around is possible under the parameter constraint.

Decomposition:
- Shared package constants: PART_MAX = 2^PART_W-1, SUM_MAX = N_PARTS*PART_MAX, state encoding (IDLE=2'd0, EMIT=2'd1, FIN=2'd2).
- One natural sub-module: part_clamp. It is combinational, computes min(remaining, PART_MAX) and remaining-min, and is reused for operand and next-remaining.
- FSM, counter and handshake stay in the top module.

Test Plan:
- total=75, out_ready=1 -> parts 15,15,15,15,15 on consecutive cycles, idx 0..4; done pulse on cycle 6; busy low after.
- total=37, out_ready=1 -> parts 15,15,7,0,0; sum 37.
- total=0 -> five parts all 0 with part_valid=1; done pulse.
- total=80 -> err pulse one cycle; part_valid never asserts; busy stays 0. A following start with total=20 then yields 15,5,0,0,0.
- total=50 with out_ready low 3 cycles at idx=1 -> part=15, idx=1 held stable for all 3 cycles. Second start during those cycles is ignored. Final parts are 15,15,15,5,0.
- rst asserted while idx=2 -> next cycle all outputs 0, state IDLE, no done. Round-trip: feed the five parts of random totals 0..75 into the five-operand adder and check its 7-bit result equals total.
